// File: rtl/peg_l2_params.sv
// Shared constants and types for the L2 MAC receive path.
// CRC-32 constants, broadcast address and the RX frame FSM states.
package peg_l2_params;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB_20E3;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
  localparam logic [47:0] BCAST_ADDR      = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HDR,
    ST_BODY
  } rx_state_e;

  // Byte i of a MAC address in wire order (byte 0 sits in the top bits).
  function automatic logic [7:0] addr_byte(
    input logic [47:0] a,
    input logic [2:0]  i
  );
    logic [7:0] b;
    case (i)
      3'd0:    b = a[47:40];
      3'd1:    b = a[39:32];
      3'd2:    b = a[31:24];
      3'd3:    b = a[23:16];
      3'd4:    b = a[15:8];
      default: b = a[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/peg_l2_crc32_byte.sv
// Combinational one-byte step of the reflected Ethernet CRC-32.
// No final inversion; the caller owns the register and the residue check.
module peg_l2_crc32_byte
  import peg_l2_params::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] c;

  always_comb begin
    c = crc_i ^ {24'h0, data_i};
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    crc_o = c;
  end

endmodule

// File: rtl/peg_l2_mac_rx.sv
// MAC RX front-end: strips FCS through a 4-byte delay line, checks CRC,
// length, PHY error and DA filter, and emits a one-beat status per frame.
module peg_l2_mac_rx
  import peg_l2_params::*;
#(
  parameter int PKT_DATA_W  = 8,
  parameter int PKT_SIZE_W  = 16,
  parameter int MIN_FRM_LEN = 64,
  parameter int MAX_FRM_LEN = 1518,
  parameter int STAT_W      = 32
) (
  input  logic                  rmii_ref_clk,
  input  logic                  rst,
  input  logic [47:0]           config_mac_addr,
  input  logic                  config_promisc_en,
  input  logic                  pkt_valid,
  input  logic                  pkt_sop,
  input  logic                  pkt_eop,
  input  logic [PKT_DATA_W-1:0] pkt_data,
  input  logic                  pkt_error,
  output logic                  pkt_ready,
  output logic                  mac_valid,
  output logic                  mac_sop,
  output logic                  mac_eop,
  output logic [PKT_DATA_W-1:0] mac_data,
  output logic                  sts_valid,
  output logic [PKT_SIZE_W-1:0] sts_len,
  output logic                  sts_crc_err,
  output logic                  sts_runt,
  output logic                  sts_giant,
  output logic                  sts_phy_err,
  output logic                  sts_addr_miss,
  output logic [STAT_W-1:0]     stat_rx_good,
  output logic [STAT_W-1:0]     stat_rx_bad
);

  localparam logic [PKT_SIZE_W-1:0] MIN_L = PKT_SIZE_W'(MIN_FRM_LEN);
  localparam logic [PKT_SIZE_W-1:0] MAX_L = PKT_SIZE_W'(MAX_FRM_LEN);
  localparam logic [PKT_SIZE_W-1:0] DA_L  = PKT_SIZE_W'(6);

  rx_state_e state_q, state_d;
  logic [31:0] crc_q, crc_d, crc_in, crc_nx;
  logic [PKT_SIZE_W-1:0] cnt_q, cnt_d, cnt_n;
  logic [3:0][PKT_DATA_W-1:0] dly_q, dly_d;
  logic [2:0] fill_q, fill_d;
  logic eq_q, eq_d, eq_n;
  logic bc_q, bc_d, bc_n;
  logic phy_q, phy_d, phy_n;
  logic emit_q, emit_d;
  logic mv_q, mv_d, ms_q, ms_d, me_q, me_d;
  logic [PKT_DATA_W-1:0] md_q, md_d;
  logic sv_q, sv_d;
  logic [PKT_SIZE_W-1:0] slen_q, slen_d;
  logic [4:0] flg_q, flg_d;
  logic [STAT_W-1:0] good_q, good_d, bad_q, bad_d;
  logic take, abort, hdr, miss;
  logic [2:0] idx;
  logic [4:0] flg_n;

  assign take   = pkt_valid & (pkt_sop | (state_q != ST_IDLE));
  assign abort  = pkt_valid & pkt_sop & (state_q != ST_IDLE);
  assign crc_in = pkt_sop ? CRC32_INIT : crc_q;

  peg_l2_crc32_byte u_crc (
    .crc_i  (crc_in),
    .data_i (pkt_data),
    .crc_o  (crc_nx)
  );

  // Per-byte running values; a sop byte restarts them.
  always_comb begin
    cnt_n = pkt_sop ? PKT_SIZE_W'(1)
          : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);
    hdr   = pkt_sop | (cnt_q < DA_L);
    idx   = pkt_sop ? 3'd0 : cnt_q[2:0];
    eq_n  = (pkt_sop | eq_q) &
            (!hdr | (pkt_data == addr_byte(config_mac_addr, idx)));
    bc_n  = (pkt_sop | bc_q) &
            (!hdr | (pkt_data == addr_byte(BCAST_ADDR, idx)));
    phy_n = (!pkt_sop & phy_q) | pkt_error;
    miss  = !((cnt_n >= DA_L) &
              (config_promisc_en | eq_n | bc_n));
    flg_n = {crc_nx != CRC32_RESIDUE, cnt_n < MIN_L,
             cnt_n > MAX_L, phy_n, miss};
  end

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    dly_d   = dly_q;
    fill_d  = fill_q;
    eq_d    = eq_q;
    bc_d    = bc_q;
    phy_d   = phy_q;
    emit_d  = emit_q;
    mv_d    = 1'b0;
    ms_d    = 1'b0;
    me_d    = 1'b0;
    md_d    = '0;
    sv_d    = 1'b0;
    slen_d  = '0;
    flg_d   = '0;
    good_d  = good_q;
    bad_d   = bad_q;
    if (take) begin
      crc_d   = crc_nx;
      cnt_d   = cnt_n;
      eq_d    = eq_n;
      bc_d    = bc_n;
      phy_d   = phy_n;
      state_d = (cnt_n >= DA_L) ? ST_BODY : ST_HDR;
      if (pkt_sop) begin
        dly_d    = '0;
        dly_d[0] = pkt_data;
        fill_d   = 3'd1;
        emit_d   = 1'b0;
        if (abort) begin
          // Lost eop: close the old frame before the new one starts.
          mv_d   = emit_q;
          me_d   = emit_q;
          sv_d   = 1'b1;
          slen_d = cnt_q;
          flg_d  = 5'b00010;
          bad_d  = bad_q + 1'b1;
        end
      end else if (fill_q == 3'd4) begin
        mv_d   = 1'b1;
        ms_d   = !emit_q;
        me_d   = pkt_eop;
        md_d   = dly_q[0];
        dly_d  = {pkt_data, dly_q[3:1]};
        emit_d = 1'b1;
      end else begin
        dly_d[fill_q[1:0]] = pkt_data;
        fill_d = fill_q + 3'd1;
      end
      if (pkt_eop) begin
        state_d = ST_IDLE;
        crc_d   = CRC32_INIT;
        cnt_d   = '0;
        fill_d  = '0;
        emit_d  = 1'b0;
        if (!abort) begin
          sv_d   = 1'b1;
          slen_d = cnt_n;
          flg_d  = flg_n;
          if (|flg_n) bad_d  = bad_q + 1'b1;
          else        good_d = good_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge rmii_ref_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      crc_q   <= CRC32_INIT;
      cnt_q   <= '0;
      dly_q   <= '0;
      fill_q  <= '0;
      eq_q    <= 1'b0;
      bc_q    <= 1'b0;
      phy_q   <= 1'b0;
      emit_q  <= 1'b0;
      mv_q    <= 1'b0;
      ms_q    <= 1'b0;
      me_q    <= 1'b0;
      md_q    <= '0;
      sv_q    <= 1'b0;
      slen_q  <= '0;
      flg_q   <= '0;
      good_q  <= '0;
      bad_q   <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      fill_q  <= fill_d;
      eq_q    <= eq_d;
      bc_q    <= bc_d;
      phy_q   <= phy_d;
      emit_q  <= emit_d;
      mv_q    <= mv_d;
      ms_q    <= ms_d;
      me_q    <= me_d;
      md_q    <= md_d;
      sv_q    <= sv_d;
      slen_q  <= slen_d;
      flg_q   <= flg_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
    end
  end

  assign pkt_ready     = 1'b1;
  assign mac_valid     = mv_q;
  assign mac_sop       = ms_q;
  assign mac_eop       = me_q;
  assign mac_data      = md_q;
  assign sts_valid     = sv_q;
  assign sts_len       = slen_q;
  assign sts_crc_err   = flg_q[4];
  assign sts_runt      = flg_q[3];
  assign sts_giant     = flg_q[2];
  assign sts_phy_err   = flg_q[1];
  assign sts_addr_miss = flg_q[0];
  assign stat_rx_good  = good_q;
  assign stat_rx_bad   = bad_q;

endmodule

// File: tb/tb_peg_l2_mac_rx.sv
// Directed bench for peg_l2_mac_rx: frames are built with a real FCS
// and the emitted beats and status are compared to expected values.
module tb_peg_l2_mac_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] config_mac_addr;
  logic        config_promisc_en;
  logic        pkt_valid, pkt_sop, pkt_eop, pkt_error;
  logic [7:0]  pkt_data;
  logic        pkt_ready;
  logic        mac_valid, mac_sop, mac_eop;
  logic [7:0]  mac_data;
  logic        sts_valid;
  logic [15:0] sts_len;
  logic        sts_crc_err, sts_runt, sts_giant;
  logic        sts_phy_err, sts_addr_miss;
  logic [31:0] stat_rx_good, stat_rx_bad;

  always #10 clk = ~clk;

  peg_l2_mac_rx dut (
    .rmii_ref_clk      (clk),
    .rst               (rst),
    .config_mac_addr   (config_mac_addr),
    .config_promisc_en (config_promisc_en),
    .pkt_valid         (pkt_valid),
    .pkt_sop           (pkt_sop),
    .pkt_eop           (pkt_eop),
    .pkt_data          (pkt_data),
    .pkt_error         (pkt_error),
    .pkt_ready         (pkt_ready),
    .mac_valid         (mac_valid),
    .mac_sop           (mac_sop),
    .mac_eop           (mac_eop),
    .mac_data          (mac_data),
    .sts_valid         (sts_valid),
    .sts_len           (sts_len),
    .sts_crc_err       (sts_crc_err),
    .sts_runt          (sts_runt),
    .sts_giant         (sts_giant),
    .sts_phy_err       (sts_phy_err),
    .sts_addr_miss     (sts_addr_miss),
    .stat_rx_good      (stat_rx_good),
    .stat_rx_bad       (stat_rx_bad)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0]  fr [0:2047];
  logic [9:0]  mq [$];
  logic [20:0] sq [$];

  localparam logic [47:0] MY_DA = 48'h0011_2233_4455;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (mac_valid) mq.push_back({mac_sop, mac_eop, mac_data});
    if (sts_valid)
      sq.push_back({sts_len, sts_crc_err, sts_runt, sts_giant,
                    sts_phy_err, sts_addr_miss});
  end

  function automatic logic [31:0] crc_upd(input logic [31:0] c,
                                          input logic [7:0] d);
    logic fb;
    for (int b = 0; b < 8; b++) begin
      fb = c[0] ^ d[b];
      c  = c >> 1;
      if (fb) c = c ^ 32'hEDB8_8320;
    end
    return c;
  endfunction

  task automatic build(input logic [47:0] da, input int n);
    logic [31:0] c;
    for (int i = 0; i < n; i++) begin
      if (i < 6)       fr[i] = da[47-8*i -: 8];
      else if (i < 12) fr[i] = (i == 11) ? 8'h01 : 8'h00;
      else             fr[i] = 8'(i * 7 + 3) ^ 8'(n);
    end
    if (n >= 8) begin
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < n - 4; i++) c = crc_upd(c, fr[i]);
      c = ~c;
      for (int k = 0; k < 4; k++) fr[n-4+k] = c[8*k +: 8];
    end
  endtask

  task automatic drive(input int n, input int gap, input int err_at,
                       input bit no_eop);
    for (int i = 0; i < n; i++) begin
      pkt_valid = 1'b1;
      pkt_sop   = (i == 0);
      pkt_eop   = (i == n - 1) && !no_eop;
      pkt_data  = fr[i];
      pkt_error = (i == err_at);
      @(posedge clk); #1;
      pkt_valid = 1'b0;
      pkt_sop   = 1'b0;
      pkt_eop   = 1'b0;
      pkt_error = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  // flags: {crc_err, runt, giant, phy_err, addr_miss}
  task automatic check_frame(input string tag, input int beats,
                             input int len, input logic [4:0] flags,
                             input int good, input int bad);
    int nbad;
    logic [9:0] e;
    chk({tag, "_nsts"}, sq.size(), 1);
    if (sq.size() > 0) begin
      chk({tag, "_len"}, sq[0][20:5], len);
      chk({tag, "_flags"}, sq[0][4:0], flags);
    end
    chk({tag, "_beats"}, mq.size(), beats);
    nbad = 0;
    for (int i = 0; i < mq.size() && i < beats; i++) begin
      e = {i == 0, i == beats - 1, fr[i]};
      if (mq[i] !== e) nbad++;
    end
    chk({tag, "_data"}, nbad, 0);
    chk({tag, "_good"}, stat_rx_good, good);
    chk({tag, "_bad"}, stat_rx_bad, bad);
    mq.delete();
    sq.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nbad;
    rst = 1'b1;
    config_mac_addr = MY_DA;
    config_promisc_en = 1'b0;
    pkt_valid = 0; pkt_sop = 0; pkt_eop = 0;
    pkt_error = 0; pkt_data = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", pkt_ready, 1);
    chk("rst_mac_valid", mac_valid, 0);
    chk("rst_sts_valid", sts_valid, 0);
    chk("rst_good", stat_rx_good, 0);
    chk("rst_bad", stat_rx_bad, 0);
    @(posedge clk); #1;

    build(MY_DA, 64); drive(64, 0, -1, 0); settle();
    check_frame("good64", 60, 64, 5'b00000, 1, 0);

    build(MY_DA, 64); fr[20] ^= 8'h01;
    drive(64, 0, -1, 0); settle();
    check_frame("crcerr", 60, 64, 5'b10000, 1, 1);

    build(MY_DA, 40); drive(40, 0, -1, 0); settle();
    check_frame("runt40", 36, 40, 5'b01000, 1, 2);

    build(MY_DA, 1519); drive(1519, 0, -1, 0); settle();
    check_frame("giant", 1515, 1519, 5'b00100, 1, 3);

    build(MY_DA, 3); drive(3, 0, -1, 0); settle();
    check_frame("short3", 0, 3, 5'b11001, 1, 4);

    build(48'hFFFF_FFFF_FFFF, 64); drive(64, 0, -1, 0); settle();
    check_frame("bcast", 60, 64, 5'b00000, 2, 4);

    build(48'h0011_2233_4456, 64); drive(64, 0, -1, 0); settle();
    check_frame("damiss", 60, 64, 5'b00001, 2, 5);

    config_promisc_en = 1'b1;
    drive(64, 0, -1, 0); settle();
    check_frame("promisc", 60, 64, 5'b00000, 3, 5);
    config_promisc_en = 1'b0;

    build(MY_DA, 100); drive(100, 0, 30, 0); settle();
    check_frame("phyerr", 96, 100, 5'b00010, 3, 6);

    // Lost eop at byte 50, then a good frame back to back.
    build(MY_DA, 100); drive(50, 0, -1, 1);
    build(MY_DA, 64); drive(64, 0, -1, 0); settle();
    chk("abort_nsts", sq.size(), 2);
    if (sq.size() == 2) begin
      chk("abort_phy", sq[0][1], 1);
      chk("abort_len", sq[0][20:5], 50);
      chk("abort_next_flags", sq[1][4:0], 0);
      chk("abort_next_len", sq[1][20:5], 64);
    end
    chk("abort_beats", mq.size(), 107);
    if (mq.size() == 107) begin
      chk("abort_beat", mq[46], {2'b01, 8'h00});
      nbad = 0;
      for (int i = 0; i < 60; i++)
        if (mq[47+i] !== {i == 0, i == 59, fr[i]}) nbad++;
      chk("abort_next_data", nbad, 0);
    end
    chk("abort_good", stat_rx_good, 4);
    chk("abort_bad", stat_rx_bad, 7);
    mq.delete(); sq.delete();

    build(MY_DA, 64); drive(64, 39, -1, 0); settle();
    check_frame("slow10m", 60, 64, 5'b00000, 5, 7);

    fr[0] = 8'h00; drive(1, 0, -1, 0); settle();
    check_frame("onebyte", 0, 1, 5'b11001, 5, 8);

    build(MY_DA, 64); drive(30, 0, -1, 1);
    chk("rst_mid_nsts", sq.size(), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid", mac_valid, 0);
    chk("rst_mid_sts", sts_valid, 0);
    chk("rst_mid_good", stat_rx_good, 0);
    chk("rst_mid_bad", stat_rx_bad, 0);
    @(posedge clk); #1 rst = 1'b0;
    mq.delete(); sq.delete();
    @(posedge clk); #1;
    drive(64, 0, -1, 0); settle();
    check_frame("after_rst", 60, 64, 5'b00000, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/peg_l2_mac_rx.md
Name: peg_l2_mac_rx

Overview:
- MAC receive front-end directly downstream of the RMII RX reconciliation sub-layer.
- Consumes its byte-wide packet stream (valid/sop/eop/data/error) and strips the 4-byte FCS, delaying data by 4 bytes.
- Checks CRC-32, frame length, PHY error and destination-address filtering.
- Emits the stripped frame plus a one-beat status word to the RX buffer, and maintains good/bad frame counters.

Parameters:
- PKT_DATA_W, 8, byte-lane width; only 8 is supported.
- PKT_SIZE_W, 16, width of length fields.
- MIN_FRM_LEN, 64, minimum legal frame length in bytes, DA through FCS inclusive.
- MAX_FRM_LEN, 1518, maximum legal frame length in bytes, DA through FCS inclusive.
- STAT_W, 32, width of the statistics counters.

Ports:
- rmii_ref_clk  in  1  sole clock; the same clock as the RS layer.
- rst  in  1  asynchronous, active-high reset.
- config_mac_addr  in  48  station address; byte 0 is at [47:40] and is received first.
- config_promisc_en  in  1  when 1, every DA is treated as a match.
- pkt_valid  in  1  input byte strobe.
- pkt_sop  in  1  first byte of a frame (the DA byte 0).
- pkt_eop  in  1  last byte of a frame.
- pkt_data  in  PKT_DATA_W  frame byte.
- pkt_error  in  1  PHY error, latched by the RS layer up to eop.
- pkt_ready  out  1  tied to 1; this block never backpressures.
- mac_valid/mac_sop/mac_eop  out  1 each  output frame beat strobes.
- mac_data  out  PKT_DATA_W  output byte.
- sts_valid  out  1  one-cycle status pulse.
- sts_len  out  PKT_SIZE_W  received length including FCS; saturates at all-ones.
- sts_crc_err, sts_runt, sts_giant, sts_phy_err, sts_addr_miss  out  1 each  frame status flags.
- stat_rx_good, stat_rx_bad  out  STAT_W  wrapping frame counters.

Behaviour:
- Reset: the one clock is rmii_ref_clk; reset rst is asynchronous and active-high. All outputs reset to 0 except pkt_ready, which is 1. FSM resets to IDLE, CRC to 32'hFFFFFFFF, the 4-byte delay line to empty.
- FSM states:
  - IDLE: pkt_valid&pkt_sop goes to HDR, with the CRC seeded from that byte and byte_cnt=1.
  - HDR: bytes 0..5; each byte is compared against the matching config_mac_addr byte. The DA matches if equal, if DA==FF:FF:FF:FF:FF:FF, or if promisc is set. After the 6th byte go to BODY.
  - BODY: continue until eop.
  - eop in HDR or BODY returns to IDLE.
- Delay line: a 4-byte shift register with a fill count.
  - A beat is output only when a valid input arrives with fill==4; the oldest byte leaves.
  - mac_* are registered, so output appears one cycle after the input beat.
  - mac_sop marks the first emitted byte of a frame.
  - mac_eop is asserted on the byte emitted by the input eop beat, which is the last byte before the FCS.
- Short frame: if the frame has ≤4 bytes at eop, no mac beat is emitted; status is still emitted.
- CRC-32: reflected, polynomial 0xEDB88320, init all-ones, computed over every byte including the FCS. The result is good iff the register after the eop byte equals 32'hDEBB20E3.
- Status: sts_valid pulses in the same cycle as mac_eop, i.e. one cycle after the input eop beat.
  - sts_runt = len<MIN_FRM_LEN.
  - sts_giant = len>MAX_FRM_LEN.
  - sts_phy_err = pkt_error seen on any beat of the frame.
  - sts_addr_miss is 1 if the DA did not match, or if eop arrived before byte 6.
  - The frame is good iff no flag is set. stat_rx_good increments on good frames; otherwise stat_rx_bad increments (once per frame).
- Byte counter: saturates at 2^PKT_SIZE_W-1 and does not wrap.
- pkt_valid low cycles (e.g. in 10 Mb/s mode): state holds, nothing is emitted.
- pkt_sop while in HDR or BODY (lost eop): the current frame is aborted.
  - If mac_sop was already emitted, emit mac_valid=1, mac_eop=1, mac_data=0x00.
  - sts_valid fires with sts_phy_err=1 and stat_rx_bad increments.
  - In the same cycle, the new sop byte starts a fresh frame: CRC reseeded, byte_cnt=1, delay line reloaded with only that byte.
- pkt_sop&pkt_eop together: a 1-byte frame, flagged runt and crc_err.
- Input without sop while in IDLE: ignored.
- Reset asserted mid-frame: all state clears immediately; no eop or status is produced for the partial frame.

Decomposition:
- peg_l2_params.sv holds CRC32_POLY_REFL, CRC32_RESIDUE, BCAST_ADDR, and the FSM enum type for IDLE/HDR/BODY.
- Sub-module peg_l2_crc32_byte: combinational next-CRC from {crc_in[31:0], data[7:0]}.
- The FSM, delay line, counters and status logic stay in the top-level block.

Test Plan:
- 64-byte frame to DA 00:11:22:33:44:55 (config matches) with correct FCS -> 60 mac beats, sop on beat 1, eop on beat 60 equal to input byte 59; sts_len=64, all flags 0; stat_rx_good=1.
- Same frame with byte 20 flipped -> sts_crc_err=1, stat_rx_bad=1, mac data still 60 bytes.
- Valid-FCS 40-byte frame -> sts_runt=1. 1519-byte frame -> sts_giant=1, len=1519. 3-byte frame -> no mac beats, sts_valid with runt=1 and crc_err=1.
- DA FF:FF:FF:FF:FF:FF -> addr_miss=0. DA 00:11:22:33:44:56 -> addr_miss=1. The same DA with config_promisc_en=1 -> addr_miss=0.
- pkt_error high on byte 30 of a good 100-byte frame -> sts_phy_err=1. New sop at byte 50 without eop -> abort beat (eop, data 0x00), phy_err status, then the next frame is received correctly.
- 10 Mb/s cadence (valid every 40 cycles) -> identical data and status. rst pulsed at byte 30 -> all outputs 0, the next frame is good.
